// File: rtl/count_sequencer.sv
// Start/pause/clear sequencer around a prescaled WIDTH-bit counter with a
// programmable terminal value, one-shot or auto-reload; COUNT_SEQ_DOWN_EN adds dir.
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
`ifdef COUNT_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           st, st_next;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic             down_q;
  logic             dir_in;
  logic             run_edge;
  logic             step;
  logic             term;

`ifdef COUNT_SEQ_DOWN_EN
  assign dir_in = dir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      down_q <= 1'b0;
    else if (!clear && start)
      down_q <= dir;
  end
`else
  assign dir_in = 1'b0;
  assign down_q = 1'b0;
`endif

  // Counting only happens on RUN edges where no control pulse is accepted.
  assign run_edge = (st == RUN) && !clear && !start && !pause;
  assign step     = run_edge && (presc == PMAX);
  assign term     = down_q ? (count == '0) : (count == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      st <= IDLE;
    else
      st <= st_next;
  end

  always_comb begin
    st_next = st;
    if (clear)
      st_next = IDLE;
    else if (start)
      st_next = RUN;
    else begin
      case (st)
        RUN:     if (pause) st_next = PAUSE;
                 else if (step && term && !reload_q) st_next = DONE;
        PAUSE:   if (pause) st_next = RUN;
        default: st_next = st;
      endcase
    end
  end

  assign state = st;
  assign busy  = (st == RUN) || (st == PAUSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      presc    <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        count <= '0;
        presc <= '0;
      end else if (start) begin
        limit_q  <= limit;
        reload_q <= auto_reload;
        count    <= dir_in ? limit : '0;
        presc    <= '0;
      end else if (run_edge) begin
        if (step) begin
          presc <= '0;
          if (term) begin
            done <= 1'b1;
            if (reload_q)
              count <= down_q ? limit_q : '0;
          end else begin
            count <= down_q ? count - WIDTH'(1) : count + WIDTH'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer (WIDTH=4, PRESCALE=4); down-mode steps
// are built only when COUNT_SEQ_DOWN_EN is defined.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, clear, auto_reload;
  logic [3:0] limit;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy, done;
`ifdef COUNT_SEQ_DOWN_EN
  logic       dir = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .limit(limit), .auto_reload(auto_reload),
`ifdef COUNT_SEQ_DOWN_EN
    .dir(dir),
`endif
    .count(count), .state(state), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int s, input int b, input int d);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".state"}, 32'(state), s);
    check({tag, ".busy"},  32'(busy),  b);
    check({tag, ".done"},  32'(done),  d);
  endtask

  task automatic do_start(input logic [3:0] lim, input logic rl);
    limit = lim; auto_reload = rl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    auto_reload = 1'b0; limit = 4'd0;
    #1;
    check_all("reset", 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();
    check_all("idle_after_reset", 0, 0, 0, 0);

    // One-shot, limit=5: increments every 4 edges, terminal at edge 24
    do_start(4'd5, 1'b0);
    check_all("oneshot_e0", 0, 1, 1, 0);
    for (int k = 1; k < 24; k++) begin
      tick();
      check("oneshot_count", 32'(count), k / 4);
      check("oneshot_done", 32'(done), 0);
      check("oneshot_state", 32'(state), 1);
    end
    tick();
    check_all("oneshot_e24", 5, 3, 0, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_all("oneshot_hold", 5, 3, 0, 0);
    end
    pause = 1'b1; tick(); pause = 1'b0;
    check_all("pause_in_done", 5, 3, 0, 0);

    // Auto-reload, limit=2: 0,1,2,0,... with done every 12 edges
    do_start(4'd2, 1'b1);
    check_all("reload_e0", 0, 1, 1, 0);
    for (int k = 1; k <= 36; k++) begin
      tick();
      check("reload_count", 32'(count), (k / 4) % 3);
      check("reload_done", 32'(done), (k % 12 == 0) ? 1 : 0);
      check("reload_state", 32'(state), 1);
    end

    // Pause with count=3, prescaler=2
    do_start(4'd9, 1'b0);
    for (int k = 1; k <= 14; k++) tick();
    check("pre_pause_count", 32'(count), 3);
    pause = 1'b1; tick(); pause = 1'b0;
    check_all("pause_enter", 3, 2, 1, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all("pause_hold", 3, 2, 1, 0);
    end
    pause = 1'b1; tick(); pause = 1'b0;
    check_all("resume", 3, 1, 1, 0);
    tick();
    check("resume_plus1", 32'(count), 3);
    tick();
    check("resume_plus2", 32'(count), 4);

    // Asynchronous reset between edges with count=3
    do_start(4'd9, 1'b0);
    for (int k = 1; k <= 12; k++) tick();
    check("pre_rst_count", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    check_all("post_rst_idle", 0, 0, 0, 0);

    // clear beats start on the same edge
    do_start(4'd9, 1'b0);
    for (int k = 1; k <= 6; k++) tick();
    check("pre_clear_count", 32'(count), 1);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    check_all("clear_over_start", 0, 0, 0, 0);

    // Restart in RUN with limit=1; later limit changes are ignored
    do_start(4'd9, 1'b0);
    for (int k = 1; k <= 5; k++) tick();
    check("pre_restart_count", 32'(count), 1);
    do_start(4'd1, 1'b0);
    check_all("restart", 0, 1, 1, 0);
    limit = 4'd7;
    for (int k = 1; k <= 4; k++) tick();
    check_all("restart_e4", 1, 1, 1, 0);
    for (int k = 1; k <= 4; k++) tick();
    check_all("restart_e8", 1, 3, 0, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_all("clear_in_done", 0, 0, 0, 0);

    // limit=0 one-shot: terminal at edge 4
    do_start(4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) tick();
    check_all("lim0_e3", 0, 1, 1, 0);
    tick();
    check_all("lim0_e4", 0, 3, 0, 1);
    tick();
    check_all("lim0_e5", 0, 3, 0, 0);

`ifdef COUNT_SEQ_DOWN_EN
    // Down mode, limit=3: 3,2,1,0 then terminal
    dir = 1'b1;
    do_start(4'd3, 1'b0);
    dir = 1'b0;
    check_all("down_e0", 3, 1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 4; j++) tick();
      check("down_count", 32'(count), 3 - k);
      check("down_done", 32'(done), 0);
    end
    for (int j = 0; j < 4; j++) tick();
    check_all("down_term", 0, 3, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit counting datapath: start/pause/clear control, prescaled step timing, programmable terminal value, one-shot or auto-reload operation.
Sits between board-level controls (buttons/switches) and counter/display logic.
Holds the count register itself and publishes run state plus a terminal-count pulse.

Parameters:
WIDTH, 4, count width in bits
PRESCALE, 4, clock cycles per count step; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; (re)start a count run
pause  input  1  single-cycle pulse; toggles RUN/PAUSE
clear  input  1  single-cycle pulse; abort to IDLE
limit  input  WIDTH  terminal count value; sampled only when start is accepted
auto_reload  input  1  1 = wrap to 0 after terminal count; 0 = stop in DONE; sampled with limit
count  output  WIDTH  current count value
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
busy  output  1  1 in RUN or PAUSE
done  output  1  one-cycle pulse on each terminal step

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- rst asserted, no clock edge needed: count=0, state=IDLE, busy=0, done=0, prescaler=0, limit_q=0, reload_q=0.
- All outputs are registered. busy is decoded from state.
- Control priority per edge: clear > start > pause.
- clear, any state: state=IDLE, count=0, prescaler=0, done=0.
- start, any state: limit_q<=limit, reload_q<=auto_reload, count=0, prescaler=0, state=RUN. A start during RUN or PAUSE restarts the run.
- pause in RUN: state=PAUSE. pause in PAUSE: state=RUN. pause in IDLE or DONE: ignored.
- On an edge that accepts pause, in either direction, neither count nor prescaler advances.
- RUN, no control accepted:
  - prescaler != PRESCALE-1: prescaler+1.
  - prescaler == PRESCALE-1: step edge, prescaler<=0.
- Step edge:
  - count != limit_q: count+1.
  - count == limit_q: done<=1 for exactly one cycle.
  - Terminal step with reload_q=1: count<=0, stay RUN.
  - Terminal step with reload_q=0: count held at limit_q, state=DONE.
- done is 0 on every other edge.
- PAUSE: count and prescaler frozen. Resuming continues from the frozen prescaler value.
- IDLE and DONE: count held.
- limit changes while not starting: ignored.
- limit_q=0: count stays 0; every step is a terminal step.
- PRESCALE=1: every RUN edge is a step edge.
- count never exceeds limit_q. No modulo-2^WIDTH wrap occurs.
- Latency: start edge gives count=0; the first increment comes PRESCALE edges later.

Optional Feature:
COUNT_SEQ_DOWN_EN
- Defined:
  - Adds input dir (1 bit), latched with limit on start.
  - dir=1 (down mode): start loads count=limit_q; each step decrements; terminal condition is count==0; reload reloads limit_q.
  - dir=0: up mode, as above.
- Undefined: dir port absent; up-count only.

Test Plan:
- Async reset mid-run: WIDTH=4, PRESCALE=4, RUN with count=3; pulse rst between edges -> count=0, state=00, busy=0 immediately, before the next edge.
- One-shot: start at edge 0, limit=5, auto_reload=0 -> count increments at edges 4,8,...,20 (reaches 5); edge 24 gives done=1 for one cycle, state=11, busy=0, count stays 5 indefinitely.
- Auto-reload: limit=2, auto_reload=1 -> count sequence 0,1,2,0,1,2 with 4-cycle holds; done pulses every 12 cycles; state stays 01.
- Pause/resume: pause accepted with count=3, prescaler=2; hold 10 cycles -> count=3, state=10 throughout; pause again -> state=01; count becomes 4 two edges after the resume edge.
- Priority and restart: clear and start on the same edge in RUN -> IDLE, count=0. start in RUN with new limit=1 -> count=0, new limit_q used. limit changed mid-run -> no effect.
- limit=0 and down mode: limit=0, auto_reload=0 -> DONE with done pulse at edge 4. With COUNT_SEQ_DOWN_EN, dir=1, limit=3 -> count 3,2,1,0; done at the step after count reaches 0.
